// File: rtl/comet_ii_pkg.sv
// Shared COMET II loader definitions: loader state encoding, frame start byte,
// byte order of data words inside a frame, and the running checksum step.
package comet_ii_pkg;

    typedef enum logic [3:0] {
        ST_MAGIC = 4'd0,
        ST_AH    = 4'd1,
        ST_AL    = 4'd2,
        ST_LH    = 4'd3,
        ST_LL    = 4'd4,
        ST_DH    = 4'd5,
        ST_DL    = 4'd6,
        ST_CHK   = 4'd7,
        ST_RUN   = 4'd8,
        ST_ERR   = 4'd9
    } load_state_e;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hC2;

    // Frames are big-endian: the first byte of each data pair is the high byte.
    localparam int WORD_HI_LSB = 8;
    localparam int WORD_LO_LSB = 0;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/comet_ii_wram.sv
// 1W1R synchronous word RAM, read-first on a same-address collision, written
// so FPGA tools map it onto block RAM.
module comet_ii_wram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem_q [0:(2**ADDR_W)-1];
    logic [15:0] rdata_q;

    // One clocked process, so a colliding read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/comet_ii_boot_loader.sv
// COMET II program loader and main memory: receives a framed image over a byte
// stream, holds the core in reset until the checksum passes, then serves the core.
module comet_ii_boot_loader
    import comet_ii_pkg::*;
#(
    parameter int          ADDR_W  = 12,
    parameter logic [15:0] SP_INIT = 16'h0000,
    parameter logic [7:0]  MAGIC   = MAGIC_DEFAULT
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        core_rst,
    output logic [15:0] core_pr_init,
    output logic [15:0] core_sp_init,
    input  logic        core_re,
    input  logic [15:0] core_raddr,
    output logic [15:0] core_rdata,
    input  logic        core_we,
    input  logic [15:0] core_waddr,
    input  logic [15:0] core_wdata,
    output logic        boot_done,
    output logic        load_err
);

    load_state_e       state_q, state_d;
    logic [15:0]       addr_q, addr_d, wptr_q, wptr_d, cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d, hi_q, hi_d;
    logic              core_rst_q, core_rst_d, boot_done_q, boot_done_d;
    logic              load_err_q, load_err_d, rd_valid_q, rd_valid_d;
    logic              rx_ready_s, rx_fire_s, ram_we_s, ram_re_s;
    logic [ADDR_W-1:0] ram_waddr_s;
    logic [15:0]       ram_wdata_s, ram_rdata_s, len_word_s;
    logic              unused_s;

    // rx_ready must already be low in the cycle rst is asserted.
    assign rx_ready_s = !rst && (state_q != ST_RUN) && (state_q != ST_ERR);
    assign rx_fire_s  = rx_valid && rx_ready_s;
    assign len_word_s = {cnt_q[15:8], rx_data};
    assign ram_re_s   = (state_q == ST_RUN) && !rst;
    // Core read enable and address high bits do not affect the memory.
    assign unused_s   = ^{core_re, core_raddr, core_waddr};

    // Loader FSM, header capture and memory write-port mux.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wptr_d      = wptr_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        hi_d        = hi_q;
        ram_we_s    = 1'b0;
        ram_waddr_s = core_waddr[ADDR_W-1:0];
        ram_wdata_s = core_wdata;
        if (rx_fire_s) begin
            case (state_q)
                ST_MAGIC: begin
                    state_d = (rx_data == MAGIC) ? ST_AH : ST_MAGIC;
                    sum_d   = 8'h00;
                end
                ST_AH: begin
                    addr_d  = {rx_data, addr_q[7:0]};
                    state_d = ST_AL;
                end
                ST_AL: begin
                    addr_d  = {addr_q[15:8], rx_data};
                    wptr_d  = {addr_q[15:8], rx_data};
                    state_d = ST_LH;
                end
                ST_LH: begin
                    cnt_d   = {rx_data, 8'h00};
                    state_d = ST_LL;
                end
                ST_LL: begin
                    cnt_d   = len_word_s;
                    state_d = (len_word_s == 16'h0000) ? ST_CHK : ST_DH;
                end
                ST_DH: begin
                    hi_d    = rx_data;
                    sum_d   = csum_add(sum_q, rx_data);
                    state_d = ST_DL;
                end
                ST_DL: begin
                    sum_d       = csum_add(sum_q, rx_data);
                    ram_we_s    = 1'b1;
                    ram_waddr_s = wptr_q[ADDR_W-1:0];
                    ram_wdata_s = (16'(hi_q) << WORD_HI_LSB) | (16'(rx_data) << WORD_LO_LSB);
                    wptr_d      = wptr_q + 16'd1;
                    cnt_d       = cnt_q - 16'd1;
                    state_d     = (cnt_q == 16'd1) ? ST_CHK : ST_DH;
                end
                ST_CHK: begin
                    state_d = (rx_data == sum_q) ? ST_RUN : ST_ERR;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else if (state_q == ST_RUN) begin
            ram_we_s = core_we && !rst;
        end else begin
            ram_we_s = 1'b0;
        end
        core_rst_d  = (state_d != ST_RUN);
        boot_done_d = (state_d == ST_RUN);
        load_err_d  = (state_d == ST_ERR);
        rd_valid_d  = (state_q == ST_RUN);
    end

    // State, header and output registers; memory contents survive rst.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q     <= ST_MAGIC;
            addr_q      <= 16'h0000;
            wptr_q      <= 16'h0000;
            cnt_q       <= 16'h0000;
            sum_q       <= 8'h00;
            hi_q        <= 8'h00;
            core_rst_q  <= 1'b1;
            boot_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wptr_q      <= wptr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            hi_q        <= hi_d;
            core_rst_q  <= core_rst_d;
            boot_done_q <= boot_done_d;
            load_err_q  <= load_err_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    comet_ii_wram #(.ADDR_W(ADDR_W)) u_wram (
        .clk   (mclk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (ram_re_s),
        .raddr (core_raddr[ADDR_W-1:0]),
        .rdata (ram_rdata_s)
    );

    assign rx_ready     = rx_ready_s;
    assign core_rst     = core_rst_q;
    assign core_pr_init = addr_q;
    assign core_sp_init = SP_INIT;
    // The RAM output register is only meaningful for reads issued in RUN.
    assign core_rdata   = rd_valid_q ? ram_rdata_s : 16'h0000;
    assign boot_done    = boot_done_q;
    assign load_err     = load_err_q;

endmodule
